// File: rtl/icache_direct_pkg.sv
// Shared constants and state encoding for the direct-mapped instruction cache.
package icache_direct_pkg;

    localparam int ADDR_WID          = 32;
    localparam int CACHE_BLK_SZ      = 512;
    localparam int ICACHE_INDEX_W    = 4;
    localparam int LINE_OFF_W        = 6;
    localparam int WORD_SEL_W        = 4;
    localparam int ICACHE_STATUS_WID = 2;

    typedef enum logic [ICACHE_STATUS_WID-1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        RESP = 2'd2
    } icache_state_e;

endpackage

// File: rtl/icache_word_sel.sv
// Picks one 32-bit instruction word out of a 64-byte cache line.
module icache_word_sel
    import icache_direct_pkg::*;
(
    input  logic [CACHE_BLK_SZ-1:0] line,
    input  logic [WORD_SEL_W-1:0]   word,
    output logic [31:0]             inst
);

    assign inst = line[{word, 5'b00000} +: 32];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache with single-line miss fill, rollback and fence.i flush.
// Optional hit/miss performance counters are built when ICACHE_PERF_EN is defined.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int INDEX_W = ICACHE_INDEX_W,
    parameter int ADDR_W  = ADDR_WID
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic                    flush,
    input  logic                    ifetch_valid,
    input  logic [ADDR_W-1:0]       ifetch_addr,
    output logic                    ifetch_ready,
    output logic                    inst_valid,
    output logic [31:0]             inst,
    output logic                    mem_find_valid,
    output logic [ADDR_W-1:0]       mem_find_addr,
    input  logic                    mem_data_valid,
    input  logic [CACHE_BLK_SZ-1:0] mem_data
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]             perf_hit_cnt,
    output logic [31:0]             perf_miss_cnt
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - LINE_OFF_W - INDEX_W;

    icache_state_e           state_q, state_d;
    logic [ADDR_W-1:0]       req_addr_q, req_addr_d;
    logic                    inst_valid_q, inst_valid_d;
    logic [31:0]             inst_q, inst_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [CACHE_BLK_SZ-1:0] data_q [LINES];

    logic [INDEX_W-1:0]      fetch_idx, req_idx;
    logic [TAG_W-1:0]        fetch_tag, req_tag;
    logic [WORD_SEL_W-1:0]   fetch_word, req_word;
    logic                    accept, hit, fill_en;
    logic [CACHE_BLK_SZ-1:0] sel_line;
    logic [WORD_SEL_W-1:0]   sel_word;
    logic [31:0]             sel_inst;
    logic                    unused_addr_bits;

    assign fetch_idx  = ifetch_addr[LINE_OFF_W +: INDEX_W];
    assign fetch_tag  = ifetch_addr[ADDR_W-1 -: TAG_W];
    assign fetch_word = ifetch_addr[LINE_OFF_W-1:2];
    assign req_idx    = req_addr_q[LINE_OFF_W +: INDEX_W];
    assign req_tag    = req_addr_q[ADDR_W-1 -: TAG_W];
    assign req_word   = req_addr_q[LINE_OFF_W-1:2];

    assign unused_addr_bits = ^{ifetch_addr[1:0], req_addr_q[1:0]};

    assign ifetch_ready   = (state_q == IDLE);
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign mem_find_valid = (state_q == MISS);
    assign mem_find_addr  = {req_addr_q[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};

    assign accept  = rdy && ifetch_valid && ifetch_ready && !rollback && !flush;
    assign hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    // The line is written even under rollback: the fetched data is still correct.
    assign fill_en = rdy && (state_q == MISS) && mem_data_valid;

    // RESP reads the line just filled; otherwise look up the incoming request.
    always_comb begin
        sel_line = data_q[fetch_idx];
        sel_word = fetch_word;
        if (state_q == RESP) begin
            sel_line = data_q[req_idx];
            sel_word = req_word;
        end
    end

    icache_word_sel u_word_sel (
        .line (sel_line),
        .word (sel_word),
        .inst (sel_inst)
    );

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        valid_d      = valid_q;
        if (rdy) begin
            inst_valid_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (hit) begin
                            inst_valid_d = 1'b1;
                            inst_d       = sel_inst;
                        end else begin
                            req_addr_d = ifetch_addr;
                            state_d    = MISS;
                        end
                    end
                end
                MISS: begin
                    if (mem_data_valid) begin
                        valid_d[req_idx] = 1'b1;
                        state_d          = RESP;
                    end
                end
                RESP: begin
                    inst_valid_d = 1'b1;
                    inst_d       = sel_inst;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (rollback || flush) begin
                state_d      = IDLE;
                inst_valid_d = 1'b0;
                inst_d       = inst_q;
            end
            if (flush) begin
                valid_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            valid_q      <= valid_d;
        end
    end

    // Tag and data storage need no reset; valid bits qualify every lookup.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= mem_data;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (accept && hit) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if (accept && !hit) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule
